// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the load-use hazard unit: default register-specifier
// width, the load-tracker entry layout and the stall-counter width.
// Optional feature macro used by the design: HAZARD_STATS_EN (stall counter).
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam int REG_ADDR_W_DEFAULT = 5;
    localparam int STALL_COUNT_W      = 32;

    // One in-flight load: dest is only meaningful while valid is set.
    typedef struct packed {
        logic                          valid;
        logic [REG_ADDR_W_DEFAULT-1:0] dest;
    } tracker_entry_t;

endpackage

// File: rtl/hazard_scoreboard_load_tracker.sv
// -----------------------------------------------------------------------------
// load_tracker
// Shift pipeline of in-flight load destinations. Advances on every edge
// because the memory stages never stall. DEPTH may be 0, in which case the
// tracker holds nothing and its outputs are tied low.
// Ports:
//   clk         - pipeline clock, rising edge
//   rst_n       - asynchronous active-low reset, clears every stage valid
//   in_valid    - a trackable load is leaving EX this cycle
//   in_dest     - its destination register
//   stage_valid - per-stage valid bits (bit k = stage k)
//   stage_dest  - per-stage destinations, stage k at [k*ADDR_W +: ADDR_W]
// -----------------------------------------------------------------------------
module load_tracker #(
    parameter int DEPTH  = 0,
    parameter int ADDR_W = 5,
    localparam int DEPTH_V = (DEPTH > 0) ? DEPTH : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [ADDR_W-1:0]          in_dest,
    output logic [DEPTH_V-1:0]         stage_valid,
    output logic [DEPTH_V*ADDR_W-1:0]  stage_dest
);

    if (DEPTH == 0) begin : g_empty
        logic unused_inputs;
        assign unused_inputs = ^{clk, rst_n, in_valid, in_dest};
        assign stage_valid   = '0;
        assign stage_dest    = '0;
    end else begin : g_stages
        logic [DEPTH-1:0]             valid_q;
        logic [DEPTH-1:0][ADDR_W-1:0] dest_q;

        // NOTE: sequential state uses non-blocking assignments so every stage
        // samples its predecessor's pre-edge value, giving a true shift.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= '0;
            end else begin
                valid_q[0] <= in_valid;
                for (int k = 1; k < DEPTH; k++) begin
                    valid_q[k] <= valid_q[k-1];
                end
            end
        end

        // NOTE: destinations are qualified by their valid bit, so they carry
        // no reset; only the valids must clear.
        always_ff @(posedge clk) begin
            dest_q[0] <= in_dest;
            for (int k = 1; k < DEPTH; k++) begin
                dest_q[k] <= dest_q[k-1];
            end
        end

        assign stage_valid = valid_q;
        assign stage_dest  = dest_q;
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Load-use hazard unit between IF/ID and ID/EX. Holds decode stalled until
// every load it depends on (in EX or still in the memory latency window) can be
// forwarded, and lets a branch flush override a stall.
// Optional feature macro: HAZARD_STATS_EN adds the saturating stallCount port.
// Ports:
//   clk, rstN           - clock and asynchronous active-low reset
//   idExValid/MemRead/Rt - instruction in EX: real, is a load, its destination
//   ifIdRs/Rt, ifIdUsesRs/Rt - sources of the decoding instruction
//   flush               - taken branch/jump squashes the IF/ID instruction
//   pcWrite, ifIdWrite  - PC and IF/ID may update
//   bubbleInstruction   - insert a NOP into ID/EX
//   stallCount          - stall cycles, saturating (HAZARD_STATS_EN only)
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W         = REG_ADDR_W_DEFAULT,
    parameter int LOAD_LATENCY       = 1,
    parameter int ZERO_REG_HARDWIRED = 1
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  idExValid,
    input  logic                  idExMemRead,
    input  logic [REG_ADDR_W-1:0] idExRt,
    input  logic [REG_ADDR_W-1:0] ifIdRs,
    input  logic [REG_ADDR_W-1:0] ifIdRt,
    input  logic                  ifIdUsesRs,
    input  logic                  ifIdUsesRt,
    input  logic                  flush,
    output logic                  pcWrite,
    output logic                  ifIdWrite,
    output logic                  bubbleInstruction
`ifdef HAZARD_STATS_EN
    ,
    output logic [STALL_COUNT_W-1:0] stallCount
`endif
);

    // EX itself covers the first latency cycle; the tracker covers the rest.
    localparam int TRACK_DEPTH = LOAD_LATENCY - 1;
    localparam int TRACK_W     = (TRACK_DEPTH > 0) ? TRACK_DEPTH : 1;

    logic                         ex_load;
    logic                         ex_track;
    logic [TRACK_W-1:0]           stage_valid;
    logic [TRACK_W*REG_ADDR_W-1:0] stage_dest;
    logic                         rs_hit;
    logic                         rt_hit;
    logic                         hazard;

    assign ex_load  = idExValid & idExMemRead;
    // Loads to the hardwired zero register can never be depended on.
    assign ex_track = ex_load & ((ZERO_REG_HARDWIRED == 0) | (idExRt != '0));

    load_tracker #(
        .DEPTH  (TRACK_DEPTH),
        .ADDR_W (REG_ADDR_W)
    ) u_tracker (
        .clk         (clk),
        .rst_n       (rstN),
        .in_valid    (ex_track),
        .in_dest     (idExRt),
        .stage_valid (stage_valid),
        .stage_dest  (stage_dest)
    );

    if (TRACK_DEPTH == 0) begin : g_no_tracker
        logic unused_stages;
        assign unused_stages = ^{stage_valid, stage_dest};
    end

    // NOTE: every always_comb output gets a default first so no path leaves a
    // signal unassigned, which would infer a latch.
    always_comb begin
        rs_hit = ex_load && (idExRt == ifIdRs);
        rt_hit = ex_load && (idExRt == ifIdRt);
        for (int k = 0; k < TRACK_DEPTH; k++) begin
            if (stage_valid[k] && (stage_dest[k*REG_ADDR_W +: REG_ADDR_W] == ifIdRs)) rs_hit = 1'b1;
            if (stage_valid[k] && (stage_dest[k*REG_ADDR_W +: REG_ADDR_W] == ifIdRt)) rt_hit = 1'b1;
        end
        hazard = (ifIdUsesRs && rs_hit && !((ZERO_REG_HARDWIRED != 0) && (ifIdRs == '0)))
               | (ifIdUsesRt && rt_hit && !((ZERO_REG_HARDWIRED != 0) && (ifIdRt == '0)));
    end

    // Priority: reset, then flush (the squashed instruction cannot stall),
    // then hazard.
    always_comb begin
        pcWrite           = 1'b1;
        ifIdWrite         = 1'b1;
        bubbleInstruction = 1'b0;
        if (!rstN) begin
            pcWrite           = 1'b0;
            ifIdWrite         = 1'b0;
            bubbleInstruction = 1'b1;
        end else if (flush) begin
            bubbleInstruction = 1'b1;
        end else if (hazard) begin
            pcWrite           = 1'b0;
            ifIdWrite         = 1'b0;
            bubbleInstruction = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [STALL_COUNT_W-1:0] stall_cnt;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stall_cnt <= '0;
        end else if (hazard && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_COUNT_W'(1);
        end
    end

    assign stallCount = stall_cnt;
`endif

endmodule
